imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 134 +++++++++++++
 tb/tb_imem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch port with misalignment/range
// faulting, flush abort and an idle-only program-load write port.
//
// state | meaning
// IDLE  | no request in flight; program writes may commit here
// BUSY  | request accepted, counting down the remaining latency
// RESP  | instr_valid is high; a new request may be accepted back-to-back
module imem_responder #(
    parameter int XLEN       = 32,
    parameter int IMEM_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pc_imem,
    input  logic                  rden_imem,
    input  logic                  flush_imem,
    output logic [XLEN-1:0]       instr_imem,
    output logic                  instr_valid,
    output logic                  fault_imem,
    output logic                  stall_imem,
    input  logic                  prog_we,
    input  logic [IMEM_WIDTH-1:0] prog_addr,
    input  logic [XLEN-1:0]       prog_data,
    output logic                  prog_drop
);

    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $fatal(1, "imem_responder: LATENCY must be in 1..8");
    end
    if (IMEM_WIDTH < 1 || IMEM_WIDTH > 29) begin : g_bad_width
        $fatal(1, "imem_responder: IMEM_WIDTH must be in 1..29");
    end

    localparam logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013);
    localparam logic [2:0]      CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [2:0]            cnt;
    logic [2:0]            cnt_next;
    logic                  accept;
    logic                  enter_resp;
    logic                  prog_commit;
    logic                  rd_fault;
    logic [31:0]           pc_q;
    logic [31:0]           rd_pc;
    logic [IMEM_WIDTH-1:0] rd_idx;

    logic [XLEN-1:0] mem [2**IMEM_WIDTH];

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        accept      = rden_imem & ~flush_imem & ((state == IDLE) | (state == RESP));
        stall_imem  = ~flush_imem & ((state == BUSY) | ((state == IDLE) & rden_imem));
        prog_commit = prog_we & (state == IDLE) & ~rden_imem;

        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = BUSY;
                        cnt_next   = CNT_INIT;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (flush_imem) begin
                    state_next = IDLE;
                end else if (cnt == 3'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // With LATENCY=1 the read happens on the accepting edge, before pc_q holds the address.
        enter_resp = (state_next == RESP);
        rd_pc      = accept ? pc_imem : pc_q;
        rd_fault   = (|rd_pc[1:0]) | (|rd_pc[31:IMEM_WIDTH+2]);
        rd_idx     = rd_pc[IMEM_WIDTH+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_imem  <= '0;
            instr_valid <= 1'b0;
            fault_imem  <= 1'b0;
            prog_drop   <= 1'b0;
            pc_q        <= 32'd0;
        end else begin
            instr_valid <= enter_resp;
            fault_imem  <= enter_resp & rd_fault;
            prog_drop   <= prog_we & ~prog_commit;
            if (accept) begin
                pc_q <= pc_imem;
            end
            if (enter_resp) begin
                instr_imem <= rd_fault ? NOP : mem[rd_idx];
            end
        end
    end

    // Writes only commit in IDLE with no request pending, so a captured response is never disturbed.
    always_ff @(posedge clk) begin
        if (prog_commit) begin
            mem[prog_addr] <= prog_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (LATENCY 2, 1, 4) with a
// queue-based scoreboard checked by an independent response monitor.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [3];
    logic [31:0] pc    [3];
    logic        rden  [3];
    logic        flush [3];
    logic        we    [3];
    logic [9:0]  paddr [3];
    logic [31:0] pdata [3];
    logic [31:0] instr [3];
    logic        valid [3];
    logic        fault [3];
    logic        stall [3];
    logic        drop  [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    imem_responder #(.XLEN(32), .IMEM_WIDTH(10), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst[0]), .pc_imem(pc[0]), .rden_imem(rden[0]), .flush_imem(flush[0]),
        .instr_imem(instr[0]), .instr_valid(valid[0]), .fault_imem(fault[0]), .stall_imem(stall[0]),
        .prog_we(we[0]), .prog_addr(paddr[0]), .prog_data(pdata[0]), .prog_drop(drop[0])
    );

    imem_responder #(.XLEN(32), .IMEM_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[1]), .pc_imem(pc[1]), .rden_imem(rden[1]), .flush_imem(flush[1]),
        .instr_imem(instr[1]), .instr_valid(valid[1]), .fault_imem(fault[1]), .stall_imem(stall[1]),
        .prog_we(we[1]), .prog_addr(paddr[1]), .prog_data(pdata[1]), .prog_drop(drop[1])
    );

    imem_responder #(.XLEN(32), .IMEM_WIDTH(10), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[2]), .pc_imem(pc[2]), .rden_imem(rden[2]), .flush_imem(flush[2]),
        .instr_imem(instr[2]), .instr_valid(valid[2]), .fault_imem(fault[2]), .stall_imem(stall[2]),
        .prog_we(we[2]), .prog_addr(paddr[2]), .prog_data(pdata[2]), .prog_drop(drop[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Request is presented during the current cycle and accepted at the next edge.
    function automatic void push_exp(input int d, input logic [31:0] i, input logic f);
        exp_t e;
        e.instr = i;
        e.fault = f;
        e.cyc   = cyc + lat_of(d);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            exp_t e;
            logic got;
            got = 1'b0;
            check($sformatf("dut%0d fault_without_valid", d), {31'd0, fault[d] & ~valid[d]}, 32'd0);
            if (valid[d] === 1'b1) begin
                case (d)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                endcase
                if (!got) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut%0d unexpected_valid: got instr %h at cycle %0d, expected no response",
                             d, instr[d], cyc);
                end else begin
                    check($sformatf("dut%0d instr", d), instr[d], e.instr);
                    check($sformatf("dut%0d fault", d), {31'd0, fault[d]}, {31'd0, e.fault});
                    check($sformatf("dut%0d resp_cycle", d), cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input int d, input logic [31:0] p, input logic [31:0] e, input logic f);
        pc[d]   = p;
        rden[d] = 1'b1;
        push_exp(d, e, f);
    endtask

    // Issues a request and holds it while stalled; returns the number of stalled cycles.
    task automatic fetch(input int d, input logic [31:0] p, input logic [31:0] e, input logic f,
                         output int ns);
        issue(d, p, e, f);
        #1;
        ns = (stall[d] === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (stall[d] === 1'b0) return;
            ns++;
        end
        check($sformatf("dut%0d fetch_timeout", d), 32'd1, 32'd0);
    endtask

    task automatic end_req(input int d);
        rden[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_word(input int d, input logic [9:0] a, input logic [31:0] v);
        we[d]    = 1'b1;
        paddr[d] = a;
        pdata[d] = v;
        @(negedge clk);
        we[d] = 1'b0;
        check($sformatf("dut%0d drop_after_idle_write", d), {31'd0, drop[d]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ns;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; pc[d] = 32'd0; rden[d] = 1'b0; flush[d] = 1'b0;
            we[d] = 1'b0; paddr[d] = 10'd0; pdata[d] = 32'd0;
        end

        // reset state
        @(negedge clk);
        #1;
        check("reset stall_idle_no_req", {31'd0, stall[0]}, 32'd0);
        rden[0] = 1'b1;
        #1;
        check("reset stall_idle_req", {31'd0, stall[0]}, 32'd1);
        rden[0] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d reset instr", d), instr[d], 32'd0);
            check($sformatf("dut%0d reset valid", d), {31'd0, valid[d]}, 32'd0);
            check($sformatf("dut%0d reset fault", d), {31'd0, fault[d]}, 32'd0);
            check($sformatf("dut%0d reset drop", d), {31'd0, drop[d]}, 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // LATENCY=2 basic fetch of word 5
        write_word(0, 10'd5, 32'h0050_0093);
        fetch(0, 32'h14, 32'h0050_0093, 1'b0, ns);
        check("l2 stall_cycles", ns, 32'd2);
        end_req(0);

        // LATENCY=1 back-to-back stream
        write_word(1, 10'd0, 32'h0010_0093);
        write_word(1, 10'd1, 32'h0020_0113);
        write_word(1, 10'd2, 32'h0030_01b3);
        fetch(1, 32'h0, 32'h0010_0093, 1'b0, ns);
        check("l1 stall_first", ns, 32'd1);
        fetch(1, 32'h4, 32'h0020_0113, 1'b0, ns);
        check("l1 stall_second", ns, 32'd0);
        fetch(1, 32'h8, 32'h0030_01b3, 1'b0, ns);
        check("l1 stall_third", ns, 32'd0);
        end_req(1);

        // misaligned and out-of-range faults, back-to-back
        fetch(0, 32'h6, NOP, 1'b1, ns);
        check("l2 fault_misaligned_stall", ns, 32'd2);
        fetch(0, 32'h1000, NOP, 1'b1, ns);
        check("l2 fault_range_stall", ns, 32'd1);
        end_req(0);

        // LATENCY=4 flush in the second BUSY cycle
        write_word(2, 10'd3, 32'h00c0_0193);
        pc[2]   = 32'hC;
        rden[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        flush[2] = 1'b1;
        #1;
        check("l4 stall_during_flush", {31'd0, stall[2]}, 32'd0);
        @(negedge clk);
        flush[2] = 1'b0;
        rden[2]  = 1'b0;
        #1;
        check("l4 idle_after_flush", {31'd0, stall[2]}, 32'd0);
        repeat (5) @(negedge clk);
        fetch(2, 32'hC, 32'h00c0_0193, 1'b0, ns);
        check("l4 stall_cycles", ns, 32'd4);
        end_req(2);

        // program write while BUSY is dropped
        issue(0, 32'h14, 32'h0050_0093, 1'b0);
        @(negedge clk);
        we[0]    = 1'b1;
        paddr[0] = 10'd5;
        pdata[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        we[0]   = 1'b0;
        rden[0] = 1'b0;
        #1;
        check("l2 drop_after_busy_write", {31'd0, drop[0]}, 32'd1);
        @(negedge clk);
        check("l2 drop_one_cycle", {31'd0, drop[0]}, 32'd0);
        fetch(0, 32'h14, 32'h0050_0093, 1'b0, ns);
        end_req(0);

        // reset in RESP with a back-to-back request pending
        fetch(0, 32'h14, 32'h0050_0093, 1'b0, ns);
        rst[0] = 1'b1;
        pc[0]  = 32'h10;
        @(negedge clk);
        check("l2 rst_resp instr", instr[0], 32'd0);
        check("l2 rst_resp valid", {31'd0, valid[0]}, 32'd0);
        check("l2 rst_resp fault", {31'd0, fault[0]}, 32'd0);
        check("l2 rst_resp drop", {31'd0, drop[0]}, 32'd0);
        rden[0] = 1'b0;
        #1;
        check("l2 rst_resp stall", {31'd0, stall[0]}, 32'd0);
        rst[0] = 1'b0;
        repeat (4) @(negedge clk);
        fetch(0, 32'h14, 32'h0050_0093, 1'b0, ns);
        check("l2 post_reset_stall", ns, 32'd2);
        end_req(0);

        repeat (6) @(negedge clk);
        check("dut0 queue_drained", q0.size(), 32'd0);
        check("dut1 queue_drained", q1.size(), 32'd0);
        check("dut2 queue_drained", q2.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
